// File: rtl/uart_transmitter.sv
// uart_transmitter: 11-bit frame serialiser (start, 8 data LSB first,
// parity, stop) paced by a 16x oversampling baud tick. CLK_HZ documents the
// clock the fixed divider table is computed for.
module uart_transmitter #(
    parameter int PARITY_EVEN = 1,
    parameter int CLK_HZ      = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    output logic       TxD,
    output logic       Tx_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  data_q;
    logic [2:0]  baud_q;
    logic        par_q;
    logic [13:0] div_cnt;
    logic [13:0] div_val;
    logic [3:0]  tick_cnt;
    logic [2:0]  idx;
    logic [2:0]  idx_nxt;
    logic        tick;
    logic        bit_done;
    logic        accept;
    logic        txd_nxt;

    if (CLK_HZ <= 0) begin : g_clk_hz_check
        $error("uart_transmitter: CLK_HZ must be positive");
    end

    // Divider period for the latched rate, in clocks per 16x tick.
    always_comb begin
        div_val = 14'd27;
        case (baud_q)
            3'b000:  div_val = 14'd10417;
            3'b001:  div_val = 14'd2604;
            3'b010:  div_val = 14'd651;
            3'b011:  div_val = 14'd326;
            3'b100:  div_val = 14'd163;
            3'b101:  div_val = 14'd81;
            3'b110:  div_val = 14'd54;
            default: div_val = 14'd27;
        endcase
    end

    assign tick     = (div_cnt == div_val - 14'd1);
    assign bit_done = tick && (tick_cnt == 4'd15);
    assign accept   = (state == S_IDLE) && Tx_WR && Tx_EN;

    // Next state, next bit index and the value TxD takes after the edge.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        txd_nxt   = 1'b1;
        if (state != S_IDLE && !Tx_EN) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (accept) state_nxt = S_START;
                S_START:  if (bit_done) begin
                              state_nxt = S_DATA;
                              idx_nxt   = 3'd0;
                          end
                S_DATA:   if (bit_done) begin
                              if (idx == 3'd7) state_nxt = S_PARITY;
                              else             idx_nxt   = idx + 3'd1;
                          end
                S_PARITY: if (bit_done) state_nxt = S_STOP;
                S_STOP:   if (bit_done) state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
        // TxD is registered from the post-edge state so the line changes on
        // the very edge that enters each bit.
        case (state_nxt)
            S_START:  txd_nxt = 1'b0;
            S_DATA:   txd_nxt = data_q[idx_nxt];
            S_PARITY: txd_nxt = par_q;
            default:  txd_nxt = 1'b1;
        endcase
    end

    // State register and registered line outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            TxD     <= 1'b1;
            Tx_BUSY <= 1'b0;
        end else begin
            state   <= state_nxt;
            TxD     <= txd_nxt;
            Tx_BUSY <= (state_nxt != S_IDLE);
        end
    end

    // Write latching, baud divider, tick counter and data index.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q   <= '0;
            baud_q   <= '0;
            par_q    <= 1'b0;
            div_cnt  <= '0;
            tick_cnt <= '0;
            idx      <= '0;
        end else if (accept) begin
            data_q   <= Tx_DATA;
            baud_q   <= baud_select;
            par_q    <= (PARITY_EVEN != 0) ? ^Tx_DATA : ~^Tx_DATA;
            div_cnt  <= '0;
            tick_cnt <= '0;
            idx      <= '0;
        end else if (state_nxt == S_IDLE) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            idx      <= '0;
        end else begin
            div_cnt  <= tick ? 14'd0 : div_cnt + 14'd1;
            if (tick) tick_cnt <= tick_cnt + 4'd1;
            idx      <= idx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: checks uart_transmitter frames against a frame model
// built from the bit-order, parity and bit-period rules.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] Tx_DATA;
    logic [2:0] baud_select;
    logic       Tx_EN;
    logic       Tx_WR;
    logic       TxD;
    logic       Tx_BUSY;

    int unsigned checks = 0;
    int unsigned errors = 0;

    uart_transmitter #(
        .PARITY_EVEN(1),
        .CLK_HZ(50_000_000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .Tx_DATA(Tx_DATA),
        .baud_select(baud_select),
        .Tx_EN(Tx_EN),
        .Tx_WR(Tx_WR),
        .TxD(TxD),
        .Tx_BUSY(Tx_BUSY)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Clocks per serial bit for each rate code.
    function automatic int unsigned bit_len(input logic [2:0] b);
        int unsigned divs [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};
        return 16 * divs[b];
    endfunction

    // Transmitted line levels in order: start, d0..d7, parity (even), stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] d);
        logic [10:0] f;
        int unsigned ones = 0;
        for (int i = 0; i < 8; i++) if (d[i]) ones++;
        f[0]    = 1'b0;
        f[8:1]  = d;
        f[9]    = (ones % 2 == 1);
        f[10]   = 1'b1;
        return f;
    endfunction

    task automatic idle_check(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_txd"}, TxD, 1);
            check({tag, "_busy"}, Tx_BUSY, 0);
        end
    endtask

    // Issue a write (caller is just after a negedge) and check the line.
    // ncyc = 0 runs the full frame and checks the return to idle; otherwise
    // the task returns at the negedge ending cycle ncyc-1 of the frame.
    task automatic run_frame(input logic [7:0] d, input logic [2:0] b,
                             input bit noise, input int unsigned ncyc);
        int unsigned L = bit_len(b);
        int unsigned total = (ncyc == 0) ? 11 * L : ncyc;
        logic [10:0] f = frame_bits(d);
        Tx_DATA = d;
        baud_select = b;
        Tx_WR = 1'b1;
        @(posedge clk);
        #1 Tx_WR = 1'b0;
        for (int unsigned k = 0; k < total; k++) begin
            int unsigned bn = k / L;
            int unsigned pos = k % L;
            @(negedge clk);
            if (pos == 0 || pos == L / 2 || pos == L - 1) begin
                check($sformatf("txd_d%02h_bit%0d_pos%0d", d, bn, pos), TxD, f[bn]);
                check($sformatf("busy_d%02h_bit%0d_pos%0d", d, bn, pos), Tx_BUSY, 1);
            end
            if (noise) begin
                Tx_DATA = 8'($urandom);
                baud_select = 3'($urandom);
                Tx_WR = ($urandom_range(0, 63) == 0);
            end
        end
        if (ncyc == 0) begin
            @(negedge clk);
            Tx_WR = 1'b0;
            check($sformatf("end_txd_d%02h", d), TxD, 1);
            check($sformatf("end_busy_d%02h", d), Tx_BUSY, 0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        Tx_EN = 1'b0;
        Tx_WR = 1'b0;
        Tx_DATA = '0;
        baud_select = '0;

        // Reset held 400 ns with random inputs.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            Tx_DATA = 8'($urandom);
            baud_select = 3'($urandom);
            Tx_EN = 1'($urandom);
            Tx_WR = 1'($urandom);
            #2;
            check("rst_txd", TxD, 1);
            check("rst_busy", Tx_BUSY, 0);
        end
        @(negedge clk);
        Tx_WR = 1'b0;
        Tx_EN = 1'b1;
        reset = 1'b1;
        idle_check("post_rst", 8);

        // Directed single frame at 115200.
        run_frame(8'h9A, 3'b111, 1'b0, 0);

        // Back-to-back frames, each written in the first non-busy cycle.
        run_frame(8'hA5, 3'b111, 1'b0, 0);
        run_frame(8'h00, 3'b111, 1'b0, 0);
        run_frame(8'hFF, 3'b111, 1'b0, 0);

        // Stray writes and rate changes during a frame must not matter.
        run_frame(8'h3C, 3'b111, 1'b1, 0);
        idle_check("no_second", 50);

        // Random data and rates with input noise mid-frame.
        for (int i = 0; i < 3; i++) begin
            run_frame(8'($urandom), 3'($urandom_range(6, 7)), 1'b1, 0);
            idle_check("rand_gap", 4);
        end

        // Abort during DATA.
        run_frame(8'h5B, 3'b111, 1'b0, 3 * 432 + 100);
        Tx_EN = 1'b0;
        @(negedge clk);
        check("abort_txd", TxD, 1);
        check("abort_busy", Tx_BUSY, 0);
        idle_check("abort_idle", 4);
        Tx_EN = 1'b1;

        // 9600 rate: first two bits carry the 5216-clock period, then abort.
        run_frame(8'hC6, 3'b011, 1'b0, 2 * 5216 + 10);
        Tx_EN = 1'b0;
        @(negedge clk);
        check("abort2_txd", TxD, 1);
        check("abort2_busy", Tx_BUSY, 0);
        Tx_EN = 1'b1;
        idle_check("abort2_idle", 2);

        // Asynchronous reset during PARITY, then a clean frame.
        run_frame(8'h71, 3'b111, 1'b0, 9 * 432 + 200);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_txd", TxD, 1);
        check("rst_mid_busy", Tx_BUSY, 0);
        @(negedge clk);
        reset = 1'b1;
        idle_check("rst_mid_idle", 2);
        run_frame(8'h2E, 3'b111, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage of the UART link. Accepts one 8-bit word per write strobe and drives it onto `TxD` as an 11-bit frame: start bit, 8 data bits LSB first, parity, stop. `TxD` connects directly to the `RxD` input of `uart_receiver`. Both blocks share the `baud_select` encoding and the 16x oversampling baud tick, so a transmitter and receiver programmed alike interoperate bit-exactly.

## Interface
Parameters:
- `PARITY_EVEN`, default 1: 1 = even parity bit (XOR of data); 0 = odd parity (inverted XOR).
- `CLK_HZ`, default 50_000_000: documents the clock the divider table below is computed for. The table itself is fixed and is not derived from this value.

Ports:
- `clk`  in  1  system clock, 50 MHz (20 ns period).
- `reset`  in  1  asynchronous, active-low reset. Asserted when 0.
- `Tx_DATA`  in  8  word to send. Sampled only on an accepted write.
- `baud_select`  in  3  rate select. Sampled only on an accepted write.
- `Tx_EN`  in  1  transmitter enable. When 0, no writes are accepted and any frame in progress is aborted.
- `Tx_WR`  in  1  single-cycle write strobe.
- `TxD`  out  1  serial line. Idles high.
- `Tx_BUSY`  out  1  high while a frame is in progress.

## Operation
- **Baud divider.** The 16x sample-tick period in clocks is selected by `baud_select`:
  - 000 = 10417 (300 Bd)
  - 001 = 2604 (1200 Bd)
  - 010 = 651 (4800 Bd)
  - 011 = 326 (9600 Bd)
  - 100 = 163 (19200 Bd)
  - 101 = 81 (38400 Bd)
  - 110 = 54 (57600 Bd)
  - 111 = 27 (115200 Bd)
- **Counters.**
  - 14-bit divider counter produces a 1-cycle tick when it reaches div-1, then wraps to 0.
  - 4-bit tick counter: one bit period = 16 ticks = 16*div clocks.
  - 3-bit data index.
- **FSM states.** IDLE → START → DATA → PARITY → STOP → IDLE.
  - IDLE: `TxD`=1, `Tx_BUSY`=0. An accepted write (`Tx_WR`=1, `Tx_EN`=1, state IDLE) latches `Tx_DATA`, `baud_select`, and the computed parity; clears the divider, tick counter and data index; moves to START.
  - START: `TxD`=0 for one bit period, then DATA.
  - DATA: `TxD`=data[index], with index 0..7. Index increments each bit period. After index 7 completes, moves to PARITY.
  - PARITY: `TxD`=parity bit for one bit period, then STOP.
  - STOP: `TxD`=1 for one bit period, then IDLE.
- **Ignored and latched inputs.**
  - `Tx_WR` outside IDLE is ignored; there is no queuing.
  - `Tx_DATA` and `baud_select` changes during a frame have no effect, because the latched copies are used.
- **Abort.** `Tx_EN`=0 in any non-IDLE state forces IDLE on the next edge: `TxD`=1, `Tx_BUSY`=0, counters cleared.
- **Reset.** Asynchronous assertion (`reset`=0) at any time forces IDLE immediately:
  - `TxD`=1, `Tx_BUSY`=0.
  - All counters and latches cleared.
- **Simultaneous events.** `Tx_WR` with `Tx_EN`=0 is not accepted.

## Timing
- Outputs are registered; `TxD` has no combinational path from any input.
- **Write to start.** A write accepted at rising edge N gives `Tx_BUSY`=1 and `TxD`=0 from edge N (visible in cycle N+1).
- **Bit length.** Each bit lasts exactly 16*div clocks. At 111 this is 432 clocks per bit; the frame is 11*432 = 4752 clocks.
- **End of frame.** `Tx_BUSY` falls on the same edge at which STOP's final tick completes, and `TxD` stays 1.
- **Back-to-back frames.** A `Tx_WR` in the first cycle with `Tx_BUSY`=0 is accepted. The next start bit follows immediately, with no extra idle bit beyond the stop bit.
- **Abort timing.** After `Tx_EN` falls, `TxD` returns high within 1 clock.

## Test plan
- **Reset.** Hold `reset`=0 for 400 ns with random inputs → `TxD`=1, `Tx_BUSY`=0 throughout; after release with no write, still idle.
- **Single frame.** `baud_select`=111, `Tx_DATA`=8'h9A, `Tx_EN`=1, one-cycle `Tx_WR` → `TxD` sequence is 0 | 0,1,0,1,1,0,0,1 | 0 | 1, each bit held 432 clocks. `Tx_BUSY` is high for 4752 clocks. With `PARITY_EVEN`=0 the parity bit is 1.
- **Loopback.** Connect to `uart_receiver` with both at 111 and send 8'hA5, then 8'h00, then 8'hFF back-to-back (each `Tx_WR` issued in the first cycle after `Tx_BUSY` falls) → the receiver pulses `Rx_VALID` three times with matching `Rx_DATA` and no `Rx_PERROR`/`Rx_FERROR`.
- **Ignored inputs.** `Tx_WR` with 8'h3C during bit 4 of a frame, and `baud_select` changed to 000 mid-frame → no effect on the current frame, no second frame, bit period stays 432 clocks.
- **Abort and rate.**
  - Drop `Tx_EN` during DATA → `TxD`=1 and `Tx_BUSY`=0 one clock later.
  - Re-enable and send at `baud_select`=011 → bit period is 5216 clocks.
- **Reset mid-frame.** Assert `reset` during PARITY → `TxD`=1 and `Tx_BUSY`=0 immediately (asynchronously); a subsequent write produces a clean full frame.
